// File: rtl/mem_wb_hilo_if.sv
// MEM-to-WB result bus: stall vector and MEM outputs in, WB pipeline register,
// architectural HI/LO and the forwarded HI/LO read port out.
interface mem_wb_hilo_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic [5:0]    stall;
   logic [DW-1:0] mem_wdata;
   logic [AW-1:0] mem_wd;
   logic          mem_wreg;
   logic [DW-1:0] mem_hi;
   logic [DW-1:0] mem_lo;
   logic          mem_whilo;
   logic [DW-1:0] wb_wdata;
   logic [AW-1:0] wb_wd;
   logic          wb_wreg;
   logic [DW-1:0] wb_hi;
   logic [DW-1:0] wb_lo;
   logic          wb_whilo;
   logic [DW-1:0] hi_o;
   logic [DW-1:0] lo_o;
   logic [DW-1:0] hi_rd;
   logic [DW-1:0] lo_rd;

   modport master (
      output stall, mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo,
      input  wb_wdata, wb_wd, wb_wreg, wb_hi, wb_lo, wb_whilo,
      input  hi_o, lo_o, hi_rd, lo_rd
   );

   modport slave (
      input  stall, mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo,
      output wb_wdata, wb_wd, wb_wreg, wb_hi, wb_lo, wb_whilo,
      output hi_o, lo_o, hi_rd, lo_rd
   );
endinterface

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with HI/LO commit one cycle after WB.
// Define HILO_FWD_EN to bypass in-flight HI/LO writes onto hi_rd/lo_rd.
module mem_wb_hilo #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic         clk,
   input  logic         rst,
   mem_wb_hilo_if.slave bus
);
   logic [DW-1:0] wb_wdata_q, wb_wdata_d;
   logic [AW-1:0] wb_wd_q,    wb_wd_d;
   logic          wb_wreg_q,  wb_wreg_d;
   logic [DW-1:0] wb_hi_q,    wb_hi_d;
   logic [DW-1:0] wb_lo_q,    wb_lo_d;
   logic          wb_whilo_q, wb_whilo_d;
   logic [DW-1:0] hi_q,       hi_d;
   logic [DW-1:0] lo_q,       lo_d;

   always_comb begin
      wb_wdata_d = wb_wdata_q;
      wb_wd_d    = wb_wd_q;
      wb_wreg_d  = wb_wreg_q;
      wb_hi_d    = wb_hi_q;
      wb_lo_d    = wb_lo_q;
      wb_whilo_d = wb_whilo_q;
      if (bus.stall[4] && !bus.stall[5]) begin
         // MEM stalled but WB advancing: insert a bubble
         wb_wdata_d = '0;
         wb_wd_d    = '0;
         wb_wreg_d  = 1'b0;
         wb_hi_d    = '0;
         wb_lo_d    = '0;
         wb_whilo_d = 1'b0;
      end else if (!bus.stall[4]) begin
         wb_wdata_d = bus.mem_wdata;
         wb_wd_d    = bus.mem_wd;
         wb_wreg_d  = bus.mem_wreg;
         wb_hi_d    = bus.mem_hi;
         wb_lo_d    = bus.mem_lo;
         wb_whilo_d = bus.mem_whilo;
      end
   end

   // Commit is not gated by stall: WB never stalls on its own
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wb_whilo_q) begin
         hi_d = wb_hi_q;
         lo_d = wb_lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_wdata_q <= '0;
         wb_wd_q    <= '0;
         wb_wreg_q  <= 1'b0;
         wb_hi_q    <= '0;
         wb_lo_q    <= '0;
         wb_whilo_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         wb_wdata_q <= wb_wdata_d;
         wb_wd_q    <= wb_wd_d;
         wb_wreg_q  <= wb_wreg_d;
         wb_hi_q    <= wb_hi_d;
         wb_lo_q    <= wb_lo_d;
         wb_whilo_q <= wb_whilo_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign bus.wb_wdata = wb_wdata_q;
   assign bus.wb_wd    = wb_wd_q;
   assign bus.wb_wreg  = wb_wreg_q;
   assign bus.wb_hi    = wb_hi_q;
   assign bus.wb_lo    = wb_lo_q;
   assign bus.wb_whilo = wb_whilo_q;
   assign bus.hi_o     = hi_q;
   assign bus.lo_o     = lo_q;

`ifdef HILO_FWD_EN
   // Youngest in-flight write wins: MEM, then WB, then architectural
   always_comb begin
      if (bus.mem_whilo) begin
         bus.hi_rd = bus.mem_hi;
         bus.lo_rd = bus.mem_lo;
      end else if (wb_whilo_q) begin
         bus.hi_rd = wb_hi_q;
         bus.lo_rd = wb_lo_q;
      end else begin
         bus.hi_rd = hi_q;
         bus.lo_rd = lo_q;
      end
   end
`else
   assign bus.hi_rd = hi_q;
   assign bus.lo_rd = lo_q;
`endif
endmodule

// File: tb/tb_mem_wb_hilo.sv
// Scoreboard bench for mem_wb_hilo: stimulus queues expected values tagged
// with a cycle and sample phase; a monitor pops and compares them.
module tb_mem_wb_hilo;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef HILO_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam int S_WDATA = 0, S_WD = 1, S_WREG = 2, S_HI = 3, S_LO = 4;
   localparam int S_WHILO = 5, S_HIO = 6, S_LOO = 7, S_HIRD = 8, S_LORD = 9;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
      int          cyc;
      int          ph;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   mem_wb_hilo_if #(.DW(DW), .AW(AW)) bus();
   mem_wb_hilo #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_sig(int id);
      case (id)
         S_WDATA: return bus.wb_wdata;
         S_WD:    return 32'(bus.wb_wd);
         S_WREG:  return 32'(bus.wb_wreg);
         S_HI:    return bus.wb_hi;
         S_LO:    return bus.wb_lo;
         S_WHILO: return 32'(bus.wb_whilo);
         S_HIO:   return bus.hi_o;
         S_LOO:   return bus.lo_o;
         S_HIRD:  return bus.hi_rd;
         default: return bus.lo_rd;
      endcase
   endfunction

   task automatic push(string name, int sig, logic [31:0] v, int c, int ph);
      exp_t e;
      e.name = name; e.sig = sig; e.exp = v; e.cyc = c; e.ph = ph;
      sb_q.push_back(e);
   endtask

   task automatic check_phase(int ph);
      logic [31:0] act;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc && sb_q[i].ph == ph) begin
            act = get_sig(sb_q[i].sig);
            n_checks++;
            if (act !== sb_q[i].exp) begin
               n_fail++;
               $display("FAIL %s cyc=%0d ph=%0d actual=0x%08h required=0x%08h",
                        sb_q[i].name, cyc, ph, act, sb_q[i].exp);
            end else begin
               $display("ok   %s cyc=%0d ph=%0d value=0x%08h", sb_q[i].name, cyc, ph, act);
            end
            sb_q.delete(i);
         end
      end
   endtask

   // Phase 0 at the falling edge, phase 1 just before the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         check_phase(0);
         #4;
         check_phase(1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_all_zero(string tag, int c);
      push({tag, "_wb_wdata"}, S_WDATA, 32'h0, c, 0);
      push({tag, "_wb_wd"},    S_WD,    32'h0, c, 0);
      push({tag, "_wb_wreg"},  S_WREG,  32'h0, c, 0);
      push({tag, "_wb_hi"},    S_HI,    32'h0, c, 0);
      push({tag, "_wb_lo"},    S_LO,    32'h0, c, 0);
      push({tag, "_wb_whilo"}, S_WHILO, 32'h0, c, 0);
      push({tag, "_hi_o"},     S_HIO,   32'h0, c, 0);
      push({tag, "_lo_o"},     S_LOO,   32'h0, c, 0);
      push({tag, "_hi_rd"},    S_HIRD,  32'h0, c, 0);
   endtask

   initial begin
      int k;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.stall = '0;
      bus.mem_wdata = '0; bus.mem_wd = '0; bus.mem_wreg = 1'b0;
      bus.mem_hi = '0; bus.mem_lo = '0; bus.mem_whilo = 1'b0;
      #2 rst = 1'b0;

      // Power-on reset
      step();
      push_all_zero("por", cyc);
      step();
      rst = 1'b1;
      step();

      // Pass-through
      k = cyc;
      bus.mem_wdata = 32'h1234_5678; bus.mem_wd = 5'd5; bus.mem_wreg = 1'b1;
      push("pass_wdata", S_WDATA, 32'h1234_5678, k + 1, 0);
      push("pass_wd",    S_WD,    32'd5,         k + 1, 0);
      push("pass_wreg",  S_WREG,  32'd1,         k + 1, 0);
      step();

      // HI/LO write and two-cycle commit
      k = cyc;
      bus.mem_wreg = 1'b0;
      bus.mem_hi = 32'hAAAA_0001; bus.mem_lo = 32'h5555_0002; bus.mem_whilo = 1'b1;
      push("hl_hi_rd_mem", S_HIRD, FWD ? 32'hAAAA_0001 : 32'h0, k, 0);
      push("hl_lo_rd_mem", S_LORD, FWD ? 32'h5555_0002 : 32'h0, k, 0);
      step();
      bus.mem_whilo = 1'b0;
      push("hl_wb_hi",     S_HI,    32'hAAAA_0001, k + 1, 0);
      push("hl_wb_lo",     S_LO,    32'h5555_0002, k + 1, 0);
      push("hl_wb_whilo",  S_WHILO, 32'd1,         k + 1, 0);
      push("hl_hi_rd_wb",  S_HIRD,  FWD ? 32'hAAAA_0001 : 32'h0, k + 1, 0);
      push("hl_hi_o",      S_HIO,   32'hAAAA_0001, k + 2, 0);
      push("hl_lo_o",      S_LOO,   32'h5555_0002, k + 2, 0);
      push("hl_whilo_clr", S_WHILO, 32'd0,         k + 2, 0);
      step();

      // Bubble discards MEM register and HI/LO writes
      k = cyc;
      bus.stall = 6'b010000;
      bus.mem_wdata = 32'h1111_1111; bus.mem_wreg = 1'b1;
      bus.mem_hi = 32'hDEAD_0000; bus.mem_lo = 32'hBEEF_0000; bus.mem_whilo = 1'b1;
      push("bub_wreg",  S_WREG,  32'd0, k + 1, 0);
      push("bub_whilo", S_WHILO, 32'd0, k + 1, 0);
      push("bub_wdata", S_WDATA, 32'd0, k + 1, 0);
      push("bub_wb_hi", S_HI,    32'd0, k + 1, 0);
      step();
      bus.stall = 6'b0; bus.mem_whilo = 1'b0; bus.mem_wreg = 1'b0;
      push("bub_hi_o_kept", S_HIO, 32'hAAAA_0001, k + 2, 0);
      step();

      // Bubble on the same edge as a pending commit: commit still happens
      k = cyc;
      bus.mem_hi = 32'h0000_CAFE; bus.mem_lo = 32'h0000_F00D; bus.mem_whilo = 1'b1;
      step();
      bus.stall = 6'b010000; bus.mem_whilo = 1'b0;
      push("bc_whilo_set", S_WHILO, 32'd1,         k + 1, 0);
      push("bc_whilo_clr", S_WHILO, 32'd0,         k + 2, 0);
      push("bc_hi_o",      S_HIO,   32'h0000_CAFE, k + 2, 0);
      push("bc_lo_o",      S_LOO,   32'h0000_F00D, k + 2, 0);
      step();
      bus.stall = 6'b0;

      // Hold for three cycles with changing MEM inputs, then release
      k = cyc;
      bus.mem_wdata = 32'hA5A5_A5A5; bus.mem_wd = 5'd7; bus.mem_wreg = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         bus.stall = 6'b110000;
         bus.mem_wdata = 32'h5A5A_5A5A + 32'(i); bus.mem_wd = 5'(9 + i); bus.mem_wreg = 1'b0;
         push("hold_wdata", S_WDATA, 32'hA5A5_A5A5, cyc + 1, 0);
         push("hold_wd",    S_WD,    32'd7,         cyc + 1, 0);
         push("hold_wreg",  S_WREG,  32'd1,         cyc + 1, 0);
         step();
      end
      bus.stall = 6'b0;
      bus.mem_wdata = 32'h3333_3333; bus.mem_wd = 5'd3; bus.mem_wreg = 1'b1;
      push("rel_wdata", S_WDATA, 32'h3333_3333, k + 5, 0);
      push("rel_wd",    S_WD,    32'd3,         k + 5, 0);
      step();

      // Forwarding priority: hi_o=1, WB HI=2, MEM HI=3
      k = cyc;
      bus.mem_wreg = 1'b0;
      bus.mem_hi = 32'd1; bus.mem_lo = 32'h10; bus.mem_whilo = 1'b1;
      step();
      bus.mem_hi = 32'd2; bus.mem_lo = 32'h20;
      step();
      bus.mem_hi = 32'd3; bus.mem_lo = 32'h30;
      push("fp_hi_o",    S_HIO,  32'd1,                   k + 2, 0);
      push("fp_hi_rd_m", S_HIRD, FWD ? 32'd3 : 32'd1,     k + 2, 0);
      push("fp_lo_rd_m", S_LORD, FWD ? 32'h30 : 32'h10,   k + 2, 0);
      @(negedge clk);
      #1;
      bus.mem_whilo = 1'b0;
      push("fp_hi_rd_w", S_HIRD, FWD ? 32'd2 : 32'd1,     k + 2, 1);
      push("fp_lo_rd_w", S_LORD, FWD ? 32'h20 : 32'h10,   k + 2, 1);
      step();

      // Asynchronous reset mid-operation with a commit in flight
      bus.mem_wdata = 32'h99; bus.mem_wd = 5'd4; bus.mem_wreg = 1'b1;
      bus.mem_hi = 32'h77; bus.mem_lo = 32'h88; bus.mem_whilo = 1'b1;
      step();
      step();
      bus.mem_whilo = 1'b0;
      bus.mem_wdata = '0; bus.mem_wd = '0; bus.mem_wreg = 1'b0;
      #1 rst = 1'b0;
      push_all_zero("arst", cyc);
      step();
      rst = 1'b1;
      push("arst_hi_o_lost", S_HIO, 32'd0, cyc + 1, 0);
      push("arst_lo_o_lost", S_LOO, 32'd0, cyc + 2, 0);
      step();

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
      foreach (sb_q[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s never sampled (cyc tag %0d) required=0x%08h",
                  sb_q[i].name, sb_q[i].cyc, sb_q[i].exp);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
